// File: rtl/max_int_serial_if.sv
// Operand/result handshake bundle for max_int_serial.
// master drives operands and out_ready; slave is the comparator.
interface max_int_serial_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             sel;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Y, sel
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Y, sel
    );
endinterface

// File: rtl/max_int_serial.sv
// Bit-serial signed max, MSB first, one bit per cycle.
// Optional MAX_INT_SERIAL_EARLY_EXIT_EN ends the compare at the first differing bit.
module max_int_serial #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    max_int_serial_if.slave      bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx_q;
    logic             decided_q;
    logic             decided_d;
    logic             gt_b_q;
    logic             gt_b_d;
    logic [WIDTH-1:0] y_q;
    logic             sel_q;
    logic             out_valid_q;
    logic             bit_a;
    logic             bit_b;
    logic             cmp_done;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.Y         = y_q;
    assign bus.sel       = sel_q;

    // The sign bit inverts the sense: a set A sign bit makes B larger.
    always_comb begin
        bit_a     = a_q[idx_q];
        bit_b     = b_q[idx_q];
        decided_d = decided_q;
        gt_b_d    = gt_b_q;
        if (!decided_q && (bit_a != bit_b)) begin
            decided_d = 1'b1;
            gt_b_d    = (idx_q == IDX_MAX) ? bit_a : bit_b;
        end
`ifdef MAX_INT_SERIAL_EARLY_EXIT_EN
        cmp_done = (idx_q == '0) || (decided_d && !decided_q);
`else
        cmp_done = (idx_q == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= IDX_MAX;
            decided_q   <= 1'b0;
            gt_b_q      <= 1'b0;
            y_q         <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q       <= bus.A;
                        b_q       <= bus.B;
                        idx_q     <= IDX_MAX;
                        decided_q <= 1'b0;
                        gt_b_q    <= 1'b0;
                        state_q   <= CMP;
                    end
                end
                CMP: begin
                    decided_q <= decided_d;
                    gt_b_q    <= gt_b_d;
                    idx_q     <= idx_q - 1'b1;
                    if (cmp_done) begin
                        y_q         <= gt_b_d ? b_q : a_q;
                        sel_q       <= gt_b_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_max_int_serial.sv
// Randomized self-checking bench for max_int_serial.
// Expected results come from signed arithmetic on the operand pair.
module tb_max_int_serial;
    localparam int W = 64;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    max_int_serial_if #(.WIDTH(W)) bus ();

    max_int_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MAX_INT_SERIAL_EARLY_EXIT_EN
        for (int j = W - 1; j >= 0; j--)
            if (a[j] != b[j]) return W - j + 1;
`endif
        return W + 1;
    endfunction

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input bit churn);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0] ey;
        logic         es;
        int           n;
        int           w;
        bit           got;
        sa = a;
        sb = b;
        es = (sb > sa);
        ey = es ? b : a;
        w  = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = (hold == 0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (churn) begin
                bus.in_valid = ~bus.in_valid;
                bus.A        = rnd64();
                bus.B        = rnd64();
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) got = 1'b1;
            else check("in_ready_cmp", 64'(bus.in_ready), 64'd0);
        end
        check("latency", 64'(n), 64'(exp_lat(a, b)));
        check("y", bus.Y, ey);
        check("sel", 64'(bus.sel), 64'(es));
        check("in_ready_done", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (churn) begin
                bus.in_valid = ~bus.in_valid;
                bus.A        = rnd64();
                bus.B        = rnd64();
            end
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_y", bus.Y, ey);
            check("hold_sel", 64'(bus.sel), 64'(es));
            check("hold_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 64'(bus.out_valid), 64'd0);
        check("in_ready_back", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           seen;
        n_chk = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("in_ready_rst", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_y", bus.Y, 64'd0);
        check("rst_sel", 64'(bus.sel), 64'd0);

        run_txn(-64'sd5, 64'sd3, 0, 1'b0);
        run_txn(-64'sd2, -64'sd7, 0, 1'b0);
        run_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1'b0);
        run_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1'b0);
        run_txn(64'd10, 64'd20, 5, 1'b1);

        // Reset in the middle of a compare.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = 64'd1;
        bus.B        = 64'd2;
        repeat (30) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_y", bus.Y, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid_rst_no_valid", 64'(seen), 64'd0);
        run_txn(64'd9, 64'd4, 0, 1'b0);

        // Reset while the result waits in DONE.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.A         = 64'd3;
        bus.B         = 64'd8;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (W + 2) @(negedge clk);
        check("done_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("done_rst_valid", 64'(bus.out_valid), 64'd0);
        check("done_rst_y", bus.Y, 64'd0);

        for (int t = 0; t < 24; t++) begin
            a = rnd64();
            unique case (t % 4)
                0: b = rnd64();
                1: b = a ^ (64'd1 << $urandom_range(0, W - 1));
                2: b = a ^ (rnd64() >> $urandom_range(1, W - 1));
                default: b = a;
            endcase
            run_txn(a, b, (t % 3 == 0) ? $urandom_range(1, 4) : 0, t[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
